i2c_cmd_sequencer: RTL and testbench
====================================

// Module: i2c_cmd_sequencer
// PURPOSE
// Upstream command front-end for the I2C transaction core (ports wr/addr/din/datard/done).
// Buffers host byte commands in a FIFO and presents one at a time to the core. Tracks the
// core's done pulse to advance, and returns a per-command response through a second FIFO.
// The core restarts a transaction immediately after every done. With no work queued, this
// block drives a harmless "park" read and discards its result.
// PARAMETERS
// CMD_DEPTH     4     command FIFO entries (power of 2, >=2)
// RSP_DEPTH     4     response FIFO entries (power of 2, >=2)
// PARK_ADDR     7'h7F 7-bit address used for idle park reads
// TIMEOUT_CYC   256   cycles without i2c_done before timeout_err sets (>=32)
// PORTS
// clk          in   1   clock, all logic on posedge
// rst          in   1   synchronous, active-high reset
// cmd_valid    in   1   host command valid
// cmd_ready    out  1   command FIFO not full
// cmd_wr       in   1   1=write byte, 0=read byte
// cmd_addr     in   7   target memory address
// cmd_data     in   8   write data (ignored for reads)
// rsp_valid    out  1   response FIFO not empty
// rsp_ready    in   1   host accepts response
// rsp_wr       out  1   echo of command type
// rsp_addr     out  7   echo of command address
// rsp_data     out  8   read: i2c_datard captured at done; write: byte written
// i2c_wr       out  1   to core wr
// i2c_addr     out  7   to core addr
// i2c_din      out  8   to core din
// i2c_datard   in   8   from core datard
// i2c_done     in   1   from core done (1-cycle pulse)
// busy         out  1   a real (non-park) command is in flight or cmd FIFO not empty
// timeout_err  out  1   sticky, set when watchdog expires; cleared only by rst
// BEHAVIOUR
// - Reset: FIFOs empty, state PARK, i2c_wr=0, i2c_addr=PARK_ADDR, i2c_din=0, rsp_valid=0,
//   cmd_ready=1, busy=0, timeout_err=0, watchdog=0. Core reset together; first done ends a park.
// - FIFOs are registered with first-word-fall-through outputs.
//   cmd push = cmd_valid&cmd_ready; rsp pop = rsp_valid&rsp_ready.
//   Simultaneous push+pop on a full/empty FIFO is legal and leaves the level unchanged.
// - FSM states: PARK (core running a park read) and ACTIVE (core running a held command).
//   i2c_* outputs change only on an edge where i2c_done=1, so they are stable through the
//   core's idle cycle and the whole next transaction.
// - On an edge with i2c_done=1:
//   - If ACTIVE: push response {held wr, held addr, wr ? held din : i2c_datard}.
//   - Issue check: issue = cmd FIFO non-empty AND (rsp_level + push_now - pop_now) < RSP_DEPTH.
//   - If issue: pop cmd, load i2c_wr/addr/din from FIFO head, go ACTIVE.
//   - Otherwise: load wr=0, addr=PARK_ADDR, din=0, go PARK.
//   - Park results are never pushed.
// - Ordering: responses appear in exact command order. At most one command is in flight.
//   A full response FIFO throttles issue (the core then runs parks); responses are never dropped.
// - i2c_done while i2c_wr/addr are changing is impossible by construction. i2c_done is only
//   acted on as a 1-cycle pulse; a 2-cycle high is treated as two completions (not expected).
// - Watchdog: counter clears on every i2c_done and increments otherwise, saturating at
//   TIMEOUT_CYC. On reaching TIMEOUT_CYC, timeout_err<=1. No abort; state is held.
// - Reset mid-command: in-flight and queued commands are discarded, no response is produced.
// - busy = (state==ACTIVE) | cmd FIFO non-empty.
// TESTING
// 1. Write 0xA5 to addr 0x12, then read 0x12 -> rsp1 {1,0x12,0xA5}, rsp2 {0,0x12,0xA5}, in order.
// 2. No commands for 5 done pulses -> i2c_addr=0x7F, i2c_wr=0 throughout; rsp_valid stays 0.
// 3. Push CMD_DEPTH+1 commands back-to-back -> cmd_ready drops after 4 accepted; all 4 complete
//    in order; the 5th is accepted once a slot frees.
// 4. Hold rsp_ready=0, queue 6 reads -> exactly 4 responses are buffered and parks run after;
//    releasing rsp_ready drains them; the remaining 2 then issue, and all 6 appear in order.
// 5. Force i2c_done low for 300 cycles -> timeout_err=1 at cycle 256 and stays 1; rst clears it.
// 6. Assert rst while ACTIVE with 2 queued -> all outputs at reset values the next cycle;
//    no stale response ever appears.

Source files
------------

// File: rtl/i2c_cmd_sequencer.sv
// Command front-end for the I2C transaction core: queues host byte commands, hands them to
// the core one at a time on each done pulse, and returns per-command responses in order.
module i2c_cmd_sequencer #(
  parameter int         CMD_DEPTH   = 4,
  parameter int         RSP_DEPTH   = 4,
  parameter logic [6:0] PARK_ADDR   = 7'h7F,
  parameter int         TIMEOUT_CYC = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_wr,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_wr,
  output logic [6:0] rsp_addr,
  output logic [7:0] rsp_data,
  output logic       i2c_wr,
  output logic [6:0] i2c_addr,
  output logic [7:0] i2c_din,
  input  logic [7:0] i2c_datard,
  input  logic       i2c_done,
  output logic       busy,
  output logic       timeout_err
);

  localparam int CAW = $clog2(CMD_DEPTH);
  localparam int RAW = $clog2(RSP_DEPTH);
  localparam int WDW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CAW:0]   CMD_FULL = (CAW + 1)'(CMD_DEPTH);
  localparam logic [RAW:0]   RSP_FULL = (RAW + 1)'(RSP_DEPTH);
  localparam logic [RAW+1:0] RSP_LIM  = (RAW + 2)'(RSP_DEPTH);
  localparam logic [WDW-1:0] WD_MAX   = WDW'(TIMEOUT_CYC);

  typedef enum logic {PARK, ACTIVE} state_t;

  state_t state, state_next;

  logic [15:0]    cmd_mem [CMD_DEPTH];
  logic [CAW-1:0] cmd_rd_ptr, cmd_wr_ptr;
  logic [CAW:0]   cmd_level;
  logic [15:0]    rsp_mem [RSP_DEPTH];
  logic [RAW-1:0] rsp_rd_ptr, rsp_wr_ptr;
  logic [RAW:0]   rsp_level;
  logic [RAW+1:0] rsp_level_proj;
  logic [WDW-1:0] wd_cnt;

  logic        cmd_push, cmd_pop, rsp_push, rsp_pop, issue;
  logic [15:0] cmd_head, rsp_head, rsp_entry;
  logic        wr_next;
  logic [6:0]  addr_next;
  logic [7:0]  din_next;

  assign cmd_ready = (cmd_level != CMD_FULL);
  assign rsp_valid = (rsp_level != '0);
  assign cmd_push  = cmd_valid & cmd_ready;
  assign rsp_pop   = rsp_valid & rsp_ready;
  assign rsp_push  = i2c_done & (state == ACTIVE);
  assign cmd_head  = cmd_mem[cmd_rd_ptr];
  assign rsp_head  = rsp_mem[rsp_rd_ptr];
  assign rsp_entry = {i2c_wr, i2c_addr, i2c_wr ? i2c_din : i2c_datard};

  assign {rsp_wr, rsp_addr, rsp_data} = rsp_head;
  assign busy = (state == ACTIVE) | (cmd_level != '0);

  // Issue only if the response for this command is guaranteed a slot when it completes.
  assign rsp_level_proj = {1'b0, rsp_level} + (RAW + 2)'(rsp_push) - (RAW + 2)'(rsp_pop);
  assign issue = i2c_done & (cmd_level != '0) & (rsp_level_proj < RSP_LIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= PARK;
      i2c_wr   <= 1'b0;
      i2c_addr <= PARK_ADDR;
      i2c_din  <= 8'h00;
    end else begin
      state    <= state_next;
      i2c_wr   <= wr_next;
      i2c_addr <= addr_next;
      i2c_din  <= din_next;
    end
  end

  always_comb begin
    state_next = state;
    wr_next    = i2c_wr;
    addr_next  = i2c_addr;
    din_next   = i2c_din;
    cmd_pop    = 1'b0;
    if (i2c_done) begin
      if (issue) begin
        cmd_pop                        = 1'b1;
        {wr_next, addr_next, din_next} = cmd_head;
        state_next                     = ACTIVE;
      end else begin
        wr_next    = 1'b0;
        addr_next  = PARK_ADDR;
        din_next   = 8'h00;
        state_next = PARK;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (cmd_push) cmd_mem[cmd_wr_ptr] <= {cmd_wr, cmd_addr, cmd_data};
    if (rsp_push) rsp_mem[rsp_wr_ptr] <= rsp_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_rd_ptr <= '0;
      cmd_wr_ptr <= '0;
      cmd_level  <= '0;
    end else begin
      if (cmd_push) cmd_wr_ptr <= cmd_wr_ptr + 1'b1;
      if (cmd_pop)  cmd_rd_ptr <= cmd_rd_ptr + 1'b1;
      case ({cmd_push, cmd_pop})
        2'b10:   cmd_level <= cmd_level + 1'b1;
        2'b01:   cmd_level <= cmd_level - 1'b1;
        default: cmd_level <= cmd_level;
      endcase
    end
  end

  // The issue rule keeps a push from ever landing on a full response FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_rd_ptr <= '0;
      rsp_wr_ptr <= '0;
      rsp_level  <= '0;
    end else begin
      if (rsp_push && (rsp_level != RSP_FULL || rsp_pop)) rsp_wr_ptr <= rsp_wr_ptr + 1'b1;
      if (rsp_pop) rsp_rd_ptr <= rsp_rd_ptr + 1'b1;
      case ({rsp_push, rsp_pop})
        2'b10:   rsp_level <= rsp_level + 1'b1;
        2'b01:   rsp_level <= rsp_level - 1'b1;
        default: rsp_level <= rsp_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else if (i2c_done) begin
      wd_cnt <= '0;
    end else if (wd_cnt != WD_MAX) begin
      wd_cnt <= wd_cnt + 1'b1;
      if (wd_cnt == WD_MAX - 1'b1) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Scoreboard bench for i2c_cmd_sequencer: a behavioural I2C core answers each transaction,
// and a monitor compares every accepted response against the expected-response queue.
module tb_i2c_cmd_sequencer;

  localparam int CORE_LAT = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0, cmd_ready, cmd_wr = 1'b0;
  logic [6:0] cmd_addr = '0;
  logic [7:0] cmd_data = '0;
  logic       rsp_valid, rsp_ready = 1'b1, rsp_wr;
  logic [6:0] rsp_addr;
  logic [7:0] rsp_data;
  logic       i2c_wr;
  logic [6:0] i2c_addr;
  logic [7:0] i2c_din;
  logic [7:0] i2c_datard = '0;
  logic       i2c_done = 1'b0;
  logic       busy, timeout_err;

  logic [15:0] exp_q[$];
  logic [7:0]  ref_mem [128];
  logic [7:0]  dev_mem [128];
  bit          core_hold = 1'b0;
  int          core_cnt;
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  i2c_cmd_sequencer dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wr(rsp_wr),
    .rsp_addr(rsp_addr), .rsp_data(rsp_data),
    .i2c_wr(i2c_wr), .i2c_addr(i2c_addr), .i2c_din(i2c_din),
    .i2c_datard(i2c_datard), .i2c_done(i2c_done),
    .busy(busy), .timeout_err(timeout_err)
  );

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Behavioural core: each transaction takes CORE_LAT cycles, then a one-cycle done pulse.
  initial begin
    for (int i = 0; i < 128; i++) dev_mem[i] = 8'(i) ^ 8'h5A;
    forever begin
      core_cnt = 0;
      while (core_cnt < CORE_LAT) begin
        @(posedge clk); #1;
        if (rst || core_hold) core_cnt = 0;
        else core_cnt++;
      end
      if (i2c_wr) dev_mem[i2c_addr] = i2c_din;
      i2c_datard = dev_mem[i2c_addr];
      i2c_done   = 1'b1;
      @(posedge clk); #1;
      i2c_done   = 1'b0;
      i2c_datard = 8'($urandom);
    end
  end

  initial begin
    logic [15:0] exp_rsp;
    forever begin
      @(negedge clk);
      if (rsp_valid && rsp_ready && !rst) begin
        if (exp_q.size() == 0) begin
          check_output("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          exp_rsp = exp_q.pop_front();
          check_output("rsp_entry", 32'({rsp_wr, rsp_addr, rsp_data}), 32'(exp_rsp));
        end
      end
    end
  end

  task automatic apply_stimulus(input logic wr, input logic [6:0] addr, input logic [7:0] data);
    bit ok = 1'b0;
    cmd_wr    = wr;
    cmd_addr  = addr;
    cmd_data  = data;
    cmd_valid = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check_output("cmd_accept_timeout", 32'(cmd_ready), 32'd1);
    end else begin
      if (wr) ref_mem[addr] = data;
      exp_q.push_back({wr, addr, ref_mem[addr]});
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy && !rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_output("idle_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic wait_dones(input int n, input bit park_checks);
    int seen = 0;
    for (int k = 0; k < 50 * n && seen < n; k++) begin
      @(negedge clk);
      if (i2c_done) begin
        seen++;
        if (park_checks) begin
          check_output("park_addr", 32'(i2c_addr), 32'h7F);
          check_output("park_wr", 32'(i2c_wr), 32'd0);
          check_output("park_rsp_valid", 32'(rsp_valid), 32'd0);
        end
      end
    end
    if (seen < n) check_output("done_timeout", 32'(seen), 32'(n));
    @(posedge clk); #1;
  endtask

  task automatic check_reset_values();
    check_output("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check_output("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_timeout_err", 32'(timeout_err), 32'd0);
    check_output("rst_i2c", 32'({i2c_wr, i2c_addr, i2c_din}), 32'({1'b0, 7'h7F, 8'h00}));
  endtask

  initial begin
    bit seen;
    for (int i = 0; i < 128; i++) ref_mem[i] = 8'(i) ^ 8'h5A;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    rst = 1'b0;

    // Write then read back the same address.
    apply_stimulus(1'b1, 7'h12, 8'hA5);
    apply_stimulus(1'b0, 7'h12, 8'h00);
    wait_idle();

    // Idle: only park reads, no responses.
    wait_dones(5, 1'b1);

    // Fill the command FIFO while the core is stalled.
    core_hold = 1'b1;
    for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 7'(8'h40 + i), 8'(8'hC0 + i));
    check_output("cmd_full_ready", 32'(cmd_ready), 32'd0);
    check_output("cmd_full_busy", 32'(busy), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    check_output("cmd_full_ready_held", 32'(cmd_ready), 32'd0);
    core_hold = 1'b0;
    apply_stimulus(1'b0, 7'h40, 8'h00);
    wait_idle();

    // Response backpressure throttles issue; core parks with commands still queued.
    rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) apply_stimulus(1'b0, 7'(8'h20 + i), 8'h00);
    wait_dones(8, 1'b0);
    check_output("throttle_rsp_valid", 32'(rsp_valid), 32'd1);
    check_output("throttle_busy", 32'(busy), 32'd1);
    check_output("throttle_park", 32'({i2c_wr, i2c_addr}), 32'({1'b0, 7'h7F}));
    check_output("throttle_cmd_ready", 32'(cmd_ready), 32'd1);
    check_output("throttle_pending", 32'(exp_q.size()), 32'd6);
    rsp_ready = 1'b1;
    wait_idle();

    // Watchdog: stall the core right after a done pulse.
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (i2c_done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check_output("wd_sync_timeout", 32'(i2c_done), 32'd1);
    @(posedge clk); #1;
    core_hold = 1'b1;
    repeat (255) @(posedge clk);
    #1;
    check_output("wd_before", 32'(timeout_err), 32'd0);
    @(posedge clk); #1;
    check_output("wd_at_limit", 32'(timeout_err), 32'd1);
    repeat (44) @(posedge clk);
    #1;
    check_output("wd_sticky", 32'(timeout_err), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_output("wd_cleared", 32'(timeout_err), 32'd0);
    core_hold = 1'b0;

    // Reset while a command is in flight with two more queued.
    apply_stimulus(1'b0, 7'h30, 8'h00);
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (i2c_addr == 7'h30) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check_output("active_timeout", 32'(i2c_addr), 32'h30);
    @(posedge clk); #1;
    core_hold = 1'b1;
    apply_stimulus(1'b0, 7'h31, 8'h00);
    apply_stimulus(1'b0, 7'h32, 8'h00);
    check_output("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_values();
    core_hold = 1'b0;
    wait_dones(6, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout: simulation did not finish, got %0d checks, expected completion", n_checks);
    $fatal(1, "[TB] global timeout");
  end

endmodule
